// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: output-port codes, destination field width,
// and the switch-allocator state encoding.
package noc_pkg;

    localparam int unsigned LOCAL = 0;
    localparam int unsigned WEST  = 1;
    localparam int unsigned NORTH = 2;
    localparam int unsigned EAST  = 3;
    localparam int unsigned SOUTH = 4;

    localparam int unsigned DPORT_W = 3;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational masked priority picker: lowest set index (fixed mode) or
// first set index after `last` modulo N (round-robin mode).
module rr_pick #(
    parameter int unsigned N       = 5,
    parameter int unsigned RR_MODE = 1,
    localparam int unsigned IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          any
);

    always_comb begin
        logic        found;
        int unsigned idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        any    = |cand;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (RR_MODE != 0) ? ((32'(last) + 1 + k) % N) : k;
            if (!found && cand[IW'(idx)]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_port_rr_arbiter.sv
// Per-output-port wormhole switch allocator: locks a grant for a whole packet
// and re-arbitrates in the release cycle so grants run back-to-back.
module out_port_rr_arbiter #(
    parameter int unsigned NUM_PORTS    = 5,
    parameter int unsigned PORT_ADDRESS = noc_pkg::LOCAL,
    parameter int unsigned DPORT_W      = noc_pkg::DPORT_W,
    parameter int unsigned RR_MODE      = 1,
    parameter int unsigned MAX_HOLD     = 0,
    localparam int unsigned IW          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] buffer_req,
    input  logic [DPORT_W-1:0]   buffer_dport [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] buffer_tail,
    input  logic                 out_ready,
    output logic [NUM_PORTS-1:0] buffer_grant,
    output logic                 grant_valid,
    output logic [IW-1:0]        grant_idx
);

    import noc_pkg::*;

    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

    arb_state_t           state;
    logic [HW-1:0]        hold;
    logic [IW-1:0]        last;
    logic [NUM_PORTS-1:0] cand;
    logic                 xfer;
    logic                 hold_expire;
    logic                 release_now;
    logic [IW-1:0]        winner;
    logic                 pick_any;

    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand[i] = buffer_req[i] && (buffer_dport[i] == DPORT_W'(PORT_ADDRESS));
        end
        xfer        = grant_valid && buffer_req[grant_idx] && out_ready;
        hold_expire = (MAX_HOLD != 0) && (hold == HOLD_LAST) && ((cand & ~buffer_grant) != '0);
        release_now = !cand[grant_idx] || (xfer && buffer_tail[grant_idx]) || hold_expire;
    end

    // `last` still names the current owner at release, so it gets lowest RR priority.
    rr_pick #(
        .N       (NUM_PORTS),
        .RR_MODE (RR_MODE)
    ) u_pick (
        .cand   (cand),
        .last   (last),
        .winner (winner),
        .any    (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            buffer_grant <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            hold         <= '0;
            last         <= IW'(NUM_PORTS - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state        <= LOCKED;
                        buffer_grant <= NUM_PORTS'(1) << winner;
                        grant_valid  <= 1'b1;
                        grant_idx    <= winner;
                        last         <= winner;
                        hold         <= '0;
                    end
                end
                LOCKED: begin
                    if (release_now) begin
                        hold <= '0;
                        if (pick_any) begin
                            buffer_grant <= NUM_PORTS'(1) << winner;
                            grant_valid  <= 1'b1;
                            grant_idx    <= winner;
                            last         <= winner;
                        end else begin
                            state        <= IDLE;
                            buffer_grant <= '0;
                            grant_valid  <= 1'b0;
                            grant_idx    <= '0;
                        end
                    end else if (MAX_HOLD != 0 && hold != HOLD_LAST) begin
                        hold <= hold + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_rr_arbiter.sv
// Directed bench for out_port_rr_arbiter: round-robin, fixed-priority and
// hold-limited instances share one stimulus stream.
module tb_out_port_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = '0;
    logic [4:0] tail = '0;
    logic       ready = 1'b0;
    logic [2:0] dport [5];

    logic [4:0] g_rr, g_fp, g_mh;
    logic       v_rr, v_fp, v_mh;
    logic [2:0] i_rr, i_fp, i_mh;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    out_port_rr_arbiter #(.NUM_PORTS(5), .PORT_ADDRESS(0), .DPORT_W(3), .RR_MODE(1), .MAX_HOLD(0)) dut_rr (
        .clk(clk), .rst(rst), .buffer_req(req), .buffer_dport(dport), .buffer_tail(tail),
        .out_ready(ready), .buffer_grant(g_rr), .grant_valid(v_rr), .grant_idx(i_rr));

    out_port_rr_arbiter #(.NUM_PORTS(5), .PORT_ADDRESS(0), .DPORT_W(3), .RR_MODE(0), .MAX_HOLD(0)) dut_fp (
        .clk(clk), .rst(rst), .buffer_req(req), .buffer_dport(dport), .buffer_tail(tail),
        .out_ready(ready), .buffer_grant(g_fp), .grant_valid(v_fp), .grant_idx(i_fp));

    out_port_rr_arbiter #(.NUM_PORTS(5), .PORT_ADDRESS(0), .DPORT_W(3), .RR_MODE(1), .MAX_HOLD(4)) dut_mh (
        .clk(clk), .rst(rst), .buffer_req(req), .buffer_dport(dport), .buffer_tail(tail),
        .out_ready(ready), .buffer_grant(g_mh), .grant_valid(v_mh), .grant_idx(i_mh));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tail = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_seq [4];
        exp_seq = '{0, 2, 4, 0};
        for (int i = 0; i < 5; i++) dport[i] = 3'd0;

        // 1: reset state, then single request from buffer 1
        tick();
        do_reset();
        check("rst_grant", g_rr, 5'b00000);
        check("rst_valid", v_rr, 0);
        check("rst_idx", i_rr, 0);
        req = 5'b00010;
        tick();
        check("t1_grant", g_rr, 5'b00010);
        check("t1_idx", i_rr, 1);
        check("t1_valid", v_rr, 1);
        req = '0;
        tick();
        check("t1_drop_grant", g_rr, 5'b00000);
        check("t1_drop_valid", v_rr, 0);

        // 2/3: single-flit packets from 0,2,4; RR rotates, fixed stays on 0
        do_reset();
        req = 5'b10101;
        tail = 5'b11111;
        ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("t2_rr_idx%0d", c), i_rr, exp_seq[c]);
            check($sformatf("t2_rr_valid%0d", c), v_rr, 1);
            check($sformatf("t3_fp_grant%0d", c), g_fp, 5'b00001);
        end

        // 4: owner 3, 4-flit packet, out_ready 1,0,1,1,0,1; buffer 1 waiting
        do_reset();
        req = 5'b01000;
        tick();
        check("t4_own3", i_rr, 3);
        req = 5'b01010;
        for (int c = 0; c < 6; c++) begin
            ready = (c == 1 || c == 4) ? 1'b0 : 1'b1;
            tail  = (c == 5) ? 5'b01000 : 5'b00000;
            tick();
            if (c < 5) check($sformatf("t4_hold%0d", c), i_rr, 3);
            else       check("t4_handoff", g_rr, 5'b00010);
            if (c == 2) check("t4_mh_before", i_mh, 3);
            if (c == 3) check("t4_mh_expire", i_mh, 1);
            if (c == 5) check("t4_fp_handoff", i_fp, 1);
        end

        // 5: hold limit with competitor 2, then saturated hold without one
        do_reset();
        ready = 1'b1;
        req = 5'b00001;
        tick();
        req = 5'b00101;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("t5_mh%0d", c), i_mh, (c < 3) ? 0 : 2);
        end
        do_reset();
        req = 5'b00001;
        tick();
        for (int c = 0; c < 22; c++) tick();
        check("t5_long_hold", g_mh, 5'b00001);
        req = 5'b00101;
        tick();
        check("t5_sat_expire", i_mh, 2);
        check("t5_nolimit", i_rr, 0);

        // 6: reset mid-packet, pointer restart, destination mismatch
        do_reset();
        req = 5'b00010;
        tick();
        check("t6_own1", i_rr, 1);
        rst = 1'b1;
        tick();
        check("t6_rst_drop", g_rr, 5'b00000);
        rst = 1'b0;
        req = 5'b00110;
        tick();
        check("t6_ptr_reset", i_rr, 1);
        do_reset();
        dport[1] = 3'd3;
        req = 5'b00110;
        tick();
        check("t6_dport_skip", i_rr, 2);
        dport[1] = 3'd0;
        dport[2] = 3'd1;
        tick();
        check("t6_dest_change", g_rr, 5'b00010);
        dport[2] = 3'd0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
